// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_loader_pkg: loader state encoding, word geometry, byte place |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } loader_state_e;

  // Big-endian placement: byte index 0 lands in bits 31:24.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_loader: streams a byte image into instruction memory words   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              start,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      LAST_IDX   = 2'(BYTES_PER_WORD - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    last_d  = last_q;
    we_d    = 1'b0;
    ready_d = ready_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (wcnt_q == FULL_COUNT) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            ready_d = 1'b0;
          end else begin
            // Word register is zeroed between words, so early in_last zero-fills.
            word_d = place_byte(word_q, bcnt_q, in_byte);
            if (in_last || (bcnt_q == LAST_IDX)) begin
              state_d = ST_WRITE;
              last_d  = in_last;
              we_d    = 1'b1;
              ready_d = 1'b0;
            end else begin
              bcnt_d = bcnt_q + 2'd1;
            end
          end
        end
      end
      ST_WRITE: begin
        ptr_d  = ptr_q + ADDR_W'(1);
        wcnt_d = wcnt_q + (ADDR_W + 1)'(1);
        bcnt_d = 2'd0;
        word_d = 32'd0;
        if (last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = ST_LOAD;
          ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          wcnt_d  = '0;
          last_d  = 1'b0;
          done_d  = 1'b0;
          hold_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= 2'd0;
      word_q  <= 32'd0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = ready_q;
  assign im_we      = we_q;
  assign im_addr    = ptr_q;
  assign im_wdata   = word_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wcnt_q;

endmodule
`default_nettype wire
